// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 host transmitter and keyboard receiver.
//   Holds the transmitter state encoding, the common keyboard command bytes,
//   and the odd-parity helper used when a command byte is accepted.
// ----------------------------------------------------------------------------
package ps2_pkg;

    // Host transmitter FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Keyboard command / response bytes
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    // PS/2 frames carry odd parity: total ones over data + parity is odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
//   Brings the asynchronous ps2_clk / ps2_dat pin levels into the sys_clk
//   domain and produces a one-cycle pulse on each device falling clock edge.
//   Shared by the host transmitter and the keyboard receiver.
//
// Ports
//   sys_clk     in   system clock
//   reset       in   synchronous, active-high reset
//   ps2_clk_in  in   raw ps2_clk pin level (async)
//   ps2_dat_in  in   raw ps2_dat pin level (async)
//   clk_sync    out  synchronised ps2_clk level
//   dat_sync    out  synchronised ps2_dat level
//   clk_fall    out  registered 1-cycle pulse: synchronised clk went 1 -> 0
// ----------------------------------------------------------------------------
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_meta;
    logic [SYNC_STAGES-1:0] dat_meta;
    logic                   clk_prev;

    // NOTE: the sync chain resets to 1 (idle bus level) rather than being left
    // unreset, so leaving reset can never fabricate a falling-edge pulse.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_meta <= '1;
            dat_meta <= '1;
            clk_prev <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_meta <= {clk_meta[SYNC_STAGES-2:0], ps2_clk_in};
            dat_meta <= {dat_meta[SYNC_STAGES-2:0], ps2_dat_in};
            clk_prev <= clk_meta[SYNC_STAGES-1];
            clk_fall <= clk_prev & ~clk_meta[SYNC_STAGES-1];
        end
    end

    assign clk_sync = clk_meta[SYNC_STAGES-1];
    assign dat_sync = dat_meta[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
//   clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop,
//   then samples the device acknowledge. Both bus lines are open-drain; this
//   block only ever asks for a line to be pulled low or released.
//
// Ports
//   sys_clk            in   system clock
//   reset              in   synchronous, active-high reset
//   tx_data[7:0]       in   command byte, captured on accept
//   tx_valid           in   send request, accepted when tx_valid & tx_ready
//   tx_ready           out  1 only while idle
//   busy               out  1 while a transfer is in progress
//   tx_done            out  1-cycle pulse at the end of every transfer
//   tx_ack_ok          out  with tx_done: device acknowledged (held until next)
//   tx_error           out  with tx_done: transfer aborted on timeout (held)
//   ps2_clk_in         in   raw ps2_clk pin level
//   ps2_dat_in         in   raw ps2_dat pin level
//   ps2_clk_drive_low  out  1 = pull ps2_clk low, 0 = release
//   ps2_dat_drive_low  out  1 = pull ps2_dat low, 0 = release
// ----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    logic             clk_sync;
    logic             dat_sync;
    logic             clk_fall;

    logic [2:0]       state;
    logic [7:0]       tx_byte;
    logic             tx_parity;
    logic [3:0]       bit_cnt;     // device falling edges seen so far (0..11)
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             ack_seen;

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .clk_fall   (clk_fall)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below reads the pre-edge values, whatever order it is written in.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            tx_byte           <= 8'h00;
            tx_parity         <= 1'b0;
            bit_cnt           <= 4'd0;
            inh_cnt           <= '0;
            to_cnt            <= '0;
            ack_seen          <= 1'b0;
            tx_ready          <= 1'b1;
            busy              <= 1'b0;
            tx_done           <= 1'b0;
            tx_ack_ok         <= 1'b0;
            tx_error          <= 1'b0;
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    if (tx_ready && tx_valid) begin
                        tx_byte           <= tx_data;
                        tx_parity         <= odd_parity(tx_data);
                        bit_cnt           <= 4'd0;
                        inh_cnt           <= '0;
                        ps2_clk_drive_low <= 1'b1;
                        tx_ready          <= 1'b0;
                        busy              <= 1'b1;
                        state             <= ST_INHIBIT;
                    end else begin
                        // Entered from a finished transfer: ready one cycle
                        // after the tx_done pulse.
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                ST_INHIBIT: begin
                    // Device clock edges here are ignored; we own the clock.
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b1;    // start bit = RTS
                        to_cnt            <= '0;
                        state             <= ST_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + INH_ONE;
                    end
                end

                ST_RTS, ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
                    if (to_cnt >= TO_LIMIT) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        tx_done           <= 1'b1;
                        tx_error          <= 1'b1;
                        tx_ack_ok         <= 1'b0;
                        state             <= ST_IDLE;
                    end else begin
                        if (clk_fall)
                            to_cnt <= '0;
                        else if (to_cnt != '1)
                            to_cnt <= to_cnt + TO_ONE;

                        case (state)
                            ST_RTS: begin
                                if (clk_fall) begin
                                    ps2_dat_drive_low <= ~tx_byte[0];
                                    bit_cnt           <= 4'd1;
                                    state             <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                // bit_cnt = k-1 for the k-th edge being handled
                                if (clk_fall) begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    if (bit_cnt < 4'd8) begin
                                        ps2_dat_drive_low <= ~tx_byte[bit_cnt[2:0]];
                                    end else if (bit_cnt == 4'd8) begin
                                        ps2_dat_drive_low <= ~tx_parity;
                                    end else begin
                                        ps2_dat_drive_low <= 1'b0;  // stop bit
                                        state             <= ST_ACK;
                                    end
                                end
                            end
                            ST_ACK: begin
                                if (clk_fall) begin
                                    ack_seen <= ~dat_sync;
                                    bit_cnt  <= bit_cnt + 4'd1;
                                    state    <= ST_WAIT_IDLE;
                                end
                            end
                            default: begin  // ST_WAIT_IDLE
                                if (clk_sync && dat_sync) begin
                                    tx_done   <= 1'b1;
                                    tx_error  <= 1'b0;
                                    tx_ack_ok <= ack_seen;
                                    state     <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with a simple keyboard model on the
//   open-drain lines. Timing parameters are scaled down so the whole run
//   stays short; the device clock half period is HALF sys_clk cycles.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 40;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error;
    logic       ps2_clk_drive_low, ps2_dat_drive_low;
    logic       ps2_clk_in, ps2_dat_in;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_dat_low = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Open-drain bus: low if either side pulls
    assign ps2_clk_in = ~(ps2_clk_drive_low | bfm_clk_low);
    assign ps2_dat_in = ~(ps2_dat_drive_low | bfm_dat_low);

    always #5 sys_clk = ~sys_clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .sys_clk           (sys_clk),
        .reset             (reset),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .tx_done           (tx_done),
        .tx_ack_ok         (tx_ack_ok),
        .tx_error          (tx_error),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_dat_in        (ps2_dat_in),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        while (!tx_ready && guard < 100) begin
            step();
            guard++;
        end
        check("send_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("accept_busy_ready", {busy, tx_ready}, 2'b10);
    endtask

    task automatic wait_done(input string tag, input logic exp_ack);
        int guard = 0;
        while (!tx_done && guard < 500) begin
            step();
            guard++;
        end
        check({tag, "_done"}, tx_done, 1);
        check({tag, "_ack_err"}, {tx_ack_ok, tx_error}, {exp_ack, 1'b0});
        check({tag, "_released"}, {ps2_clk_drive_low, ps2_dat_drive_low}, 2'b00);
        step();
        check({tag, "_ready_next"}, {tx_ready, tx_done, tx_ack_ok}, {1'b1, 1'b0, exp_ack});
    endtask

    // Keyboard model: measures the inhibit, clocks the frame out of the host
    // and optionally acknowledges. abort_edge != 0 resets the DUT while the
    // device clock is low on that edge and returns early.
    task automatic bfm_device(input logic [7:0] exp_byte, input logic exp_par,
                              input logic do_ack, input logic check_inh,
                              input int abort_edge);
        int         guard = 0;
        int         cnt   = 0;
        logic [9:0] bits  = '0;
        while (!ps2_clk_drive_low && guard < 100) begin
            step();
            guard++;
        end
        while (ps2_clk_drive_low && guard < 1000) begin
            cnt++;
            step();
            guard++;
        end
        if (check_inh) check("inhibit_len", cnt, INH);
        check("rts_lines", {ps2_clk_drive_low, ps2_dat_drive_low}, 2'b01);
        step(5);
        check("start_bit", ps2_dat_in, 0);
        for (int e = 1; e <= 10; e++) begin
            bfm_clk_low = 1'b1;
            if (e == abort_edge) begin
                step(8);
                check("pre_reset_dat_low", ps2_dat_drive_low, 1);
                bfm_clk_low = 1'b0;
                reset = 1'b1;
                step();
                check("reset_release",
                      {ps2_clk_drive_low, ps2_dat_drive_low, tx_done, tx_ready, busy},
                      5'b00010);
                reset = 1'b0;
                cnt = 0;
                for (int i = 0; i < 40; i++) begin
                    step();
                    if (tx_done) cnt++;
                end
                check("reset_no_done", cnt, 0);
                return;
            end
            step(HALF);
            bfm_clk_low = 1'b0;
            bits[e-1] = ps2_dat_in;
            step(HALF);
        end
        check("rx_byte", bits[7:0], exp_byte);
        check("rx_parity", bits[8], exp_par);
        check("rx_stop", bits[9], 1);
        if (do_ack) bfm_dat_low = 1'b1;
        step(2);
        bfm_clk_low = 1'b1;
        step(HALF);
        bfm_clk_low = 1'b0;
        step(1);
        bfm_dat_low = 1'b0;
    endtask

    initial begin
        int cnt;
        int guard;

        // Reset state
        reset = 1'b1;
        step(3);
        check("reset_outputs",
              {tx_ready, busy, tx_done, tx_ack_ok, tx_error, ps2_clk_drive_low, ps2_dat_drive_low},
              7'b1000000);
        reset = 1'b0;
        step(2);

        // 1: reset command 0xFF, parity 1, acknowledged
        send(PS2_CMD_RESET);
        bfm_device(8'hFF, 1'b1, 1'b1, 1'b1, 0);
        wait_done("t1", 1'b1);

        // 2: 0xED then 0x02 back-to-back
        send(PS2_CMD_LEDS);
        bfm_device(8'hED, 1'b1, 1'b1, 1'b1, 0);
        wait_done("t2a", 1'b1);
        send(8'h02);
        check("ack_held", {tx_ack_ok, tx_error}, 2'b10);
        bfm_device(8'h02, 1'b0, 1'b1, 1'b1, 0);
        wait_done("t2b", 1'b1);

        // 4: device never clocks after RTS -> timeout
        send(8'h55);
        guard = 0;
        while (!ps2_dat_drive_low && guard < INH + 50) begin
            step();
            guard++;
        end
        cnt = 0;
        while (ps2_dat_drive_low && cnt < TO + 50) begin
            cnt++;
            step();
        end
        check("timeout_len", cnt, TO + 1);
        check("timeout_flags",
              {tx_done, tx_error, tx_ack_ok, ps2_clk_drive_low, ps2_dat_drive_low},
              5'b11000);
        step();
        check("timeout_ready_next", {tx_ready, tx_done, tx_error}, 3'b101);

        // 3: device withholds ack -> nack, error cleared
        send(8'h3C);
        bfm_device(8'h3C, 1'b1, 1'b0, 1'b1, 0);
        wait_done("t3", 1'b0);

        // 5: reset while the device holds edge 5 low, then a clean 0xF4
        send(8'hE0);
        bfm_device(8'hE0, 1'b0, 1'b1, 1'b1, 5);
        send(PS2_CMD_ENABLE);
        bfm_device(8'hF4, 1'b0, 1'b1, 1'b1, 0);
        wait_done("t5", 1'b1);

        // 6: request while busy is ignored
        send(8'hA5);
        step(3);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("busy_ignore", {busy, tx_ready}, 2'b10);
        bfm_device(8'hA5, 1'b1, 1'b1, 1'b0, 0);
        wait_done("t6", 1'b1);
        step(60);
        check("no_second_send", {busy, ps2_clk_drive_low, ps2_dat_drive_low}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
